// File: rtl/placement_checker.sv
// placement_checker: reads back the placer's memories, optionally verifies grid/position
// consistency, then accumulates the |dx|+|dy|-1 wirelength. Optional grid scan: CHECKER_GRID_SCAN_EN.
module placement_checker #(
  parameter int N      = 9,
  parameter int N_NODE = 11,
  parameter int N_EDGE = 79
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] wirelength,
  output logic [15:0]        occupied,
  output logic [15:0]        unplaced,
  output logic [2:0]         err_flags,
  output logic               reEA,
  output logic [31:0]        addrEA,
  output logic               reEB,
  output logic [31:0]        addrEB,
  input  logic signed [31:0] doutEA,
  input  logic signed [31:0] doutEB,
  output logic               rePX,
  output logic [31:0]        addrPX,
  output logic               rePY,
  output logic [31:0]        addrPY,
  input  logic signed [31:0] doutPX,
  input  logic signed [31:0] doutPY,
  output logic               reGrid,
  output logic [31:0]        addrGrid,
  input  logic signed [31:0] doutGrid,
  output logic [4:0]         dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE; busy is high while a run
  // is in flight and done pulses for one cycle when results are final. Memory reads are
  // one-cycle re/addr strobes in ISSUE, one WAIT cycle, and dout is consumed in DATA.

  localparam int ERR_ID       = 0;
  localparam int ERR_MISMATCH = 1;
  localparam int ERR_UNPLACED = 2;
  localparam logic [31:0] LAST_EDGE = (N_EDGE > 0) ? 32'(N_EDGE - 1) : 32'd0;

  typedef enum logic [4:0] {
    IDLE,
`ifdef CHECKER_GRID_SCAN_EN
    GS_ISSUE,
    GS_WAIT,
    GS_DATA,
    GP_ISSUE,
    GP_WAIT,
    GP_CMP,
`endif
    EDGE_ISSUE,
    EDGE_WAIT,
    PA_ISSUE,
    PA_WAIT,
    PA_DATA,
    PB_ISSUE,
    PB_WAIT,
    PB_DATA,
    PB_CALC,
    ACC,
    DONE
  } state_t;

  state_t             state;
  logic [31:0]        edge_idx;
  logic [31:0]        eb_id;
  logic signed [31:0] xa, ya, xb, yb;
  logic signed [31:0] step_cost;
  logic               step_ok;

  assign dbg_state = state;

  function automatic logic in_grid(input logic signed [31:0] v);
    return (v >= 0) && (v < N);
  endfunction

  function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef CHECKER_GRID_SCAN_EN
  localparam logic [31:0] LAST_CELL = 32'(N * N - 1);
  logic [31:0]        cell_idx;
  logic signed [31:0] pos_addr;

  // Cell address a node's recorded position maps to; compared against the scanned cell.
  assign pos_addr = doutPX * N + doutPY;
`else
  logic unused_grid;
  assign unused_grid = ^doutGrid;
  assign reGrid      = 1'b0;
  assign addrGrid    = '0;
  assign occupied    = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      wirelength <= '0;
      unplaced   <= '0;
      err_flags  <= '0;
      reEA       <= 1'b0;
      addrEA     <= '0;
      reEB       <= 1'b0;
      addrEB     <= '0;
      rePX       <= 1'b0;
      addrPX     <= '0;
      rePY       <= 1'b0;
      addrPY     <= '0;
      edge_idx   <= '0;
      eb_id      <= '0;
      xa         <= '0;
      ya         <= '0;
      xb         <= '0;
      yb         <= '0;
      step_cost  <= '0;
      step_ok    <= 1'b0;
`ifdef CHECKER_GRID_SCAN_EN
      reGrid     <= 1'b0;
      addrGrid   <= '0;
      occupied   <= '0;
      cell_idx   <= '0;
`endif
    end else begin
      reEA <= 1'b0;
      reEB <= 1'b0;
      rePX <= 1'b0;
      rePY <= 1'b0;
      done <= 1'b0;
`ifdef CHECKER_GRID_SCAN_EN
      reGrid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            wirelength <= '0;
            unplaced   <= '0;
            err_flags  <= '0;
            edge_idx   <= '0;
`ifdef CHECKER_GRID_SCAN_EN
            occupied <= '0;
            cell_idx <= '0;
            reGrid   <= 1'b1;
            addrGrid <= '0;
            busy     <= 1'b1;
            state    <= GS_ISSUE;
`else
            if (N_EDGE == 0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              reEA   <= 1'b1;
              reEB   <= 1'b1;
              addrEA <= '0;
              addrEB <= '0;
              busy   <= 1'b1;
              state  <= EDGE_ISSUE;
            end
`endif
          end
        end

`ifdef CHECKER_GRID_SCAN_EN
        GS_ISSUE: state <= GS_WAIT;
        GS_WAIT:  state <= GS_DATA;

        GS_DATA: begin
          if (doutGrid != -32'sd1 && doutGrid >= 0 && doutGrid < N_NODE) begin
            occupied <= sat_inc(occupied);
            rePX     <= 1'b1;
            rePY     <= 1'b1;
            addrPX   <= doutGrid;
            addrPY   <= doutGrid;
            state    <= GP_ISSUE;
          end else begin
            if (doutGrid != -32'sd1) err_flags[ERR_ID] <= 1'b1;
            if (cell_idx == LAST_CELL) begin
              if (N_EDGE == 0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                reEA   <= 1'b1;
                reEB   <= 1'b1;
                addrEA <= '0;
                addrEB <= '0;
                state  <= EDGE_ISSUE;
              end
            end else begin
              cell_idx <= cell_idx + 32'd1;
              reGrid   <= 1'b1;
              addrGrid <= cell_idx + 32'd1;
              state    <= GS_ISSUE;
            end
          end
        end

        GP_ISSUE: state <= GP_WAIT;
        GP_WAIT:  state <= GP_CMP;

        GP_CMP: begin
          if (pos_addr != $signed(cell_idx)) err_flags[ERR_MISMATCH] <= 1'b1;
          if (cell_idx == LAST_CELL) begin
            if (N_EDGE == 0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              reEA   <= 1'b1;
              reEB   <= 1'b1;
              addrEA <= '0;
              addrEB <= '0;
              state  <= EDGE_ISSUE;
            end
          end else begin
            cell_idx <= cell_idx + 32'd1;
            reGrid   <= 1'b1;
            addrGrid <= cell_idx + 32'd1;
            state    <= GS_ISSUE;
          end
        end
`endif

        EDGE_ISSUE: state <= EDGE_WAIT;

        // Endpoint ids are valid here; a's position read is issued straight from the ROM data.
        EDGE_WAIT: begin
          rePX   <= 1'b1;
          rePY   <= 1'b1;
          addrPX <= doutEA;
          addrPY <= doutEA;
          eb_id  <= doutEB;
          state  <= PA_ISSUE;
        end

        PA_ISSUE: state <= PA_WAIT;
        PA_WAIT:  state <= PA_DATA;

        PA_DATA: begin
          xa     <= doutPX;
          ya     <= doutPY;
          rePX   <= 1'b1;
          rePY   <= 1'b1;
          addrPX <= eb_id;
          addrPY <= eb_id;
          state  <= PB_ISSUE;
        end

        PB_ISSUE: state <= PB_WAIT;
        PB_WAIT:  state <= PB_DATA;

        PB_DATA: begin
          xb    <= doutPX;
          yb    <= doutPY;
          state <= PB_CALC;
        end

        PB_CALC: begin
          step_ok   <= in_grid(xa) && in_grid(ya) && in_grid(xb) && in_grid(yb);
          step_cost <= abs32(xa - xb) + abs32(ya - yb) - 32'sd1;
          state     <= ACC;
        end

        ACC: begin
          if (step_ok) begin
            wirelength <= wirelength + step_cost;
          end else begin
            err_flags[ERR_UNPLACED] <= 1'b1;
            unplaced                <= sat_inc(unplaced);
          end
          if (edge_idx == LAST_EDGE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            edge_idx <= edge_idx + 32'd1;
            reEA     <= 1'b1;
            reEB     <= 1'b1;
            addrEA   <= edge_idx + 32'd1;
            addrEB   <= edge_idx + 32'd1;
            state    <= EDGE_ISSUE;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_placement_checker.sv
// Directed bench for placement_checker at N=4, N_NODE=11, N_EDGE=79 with behavioural
// synchronous-read memories; expectations follow CHECKER_GRID_SCAN_EN when defined.
module tb_placement_checker;

  localparam int N      = 4;
  localparam int N_NODE = 11;
  localparam int N_EDGE = 79;
  localparam int N_CELL = N * N;
`ifdef CHECKER_GRID_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic signed [31:0] wirelength;
  logic [15:0] occupied, unplaced;
  logic [2:0] err_flags;
  logic reEA, reEB, rePX, rePY, reGrid;
  logic [31:0] addrEA, addrEB, addrPX, addrPY, addrGrid;
  logic signed [31:0] doutEA = '0, doutEB = '0, doutPX = '0, doutPY = '0, doutGrid = '0;
  logic [4:0] dbg_state;

  logic signed [31:0] ea_m[N_EDGE];
  logic signed [31:0] eb_m[N_EDGE];
  logic signed [31:0] px_m[16];
  logic signed [31:0] py_m[16];
  logic signed [31:0] grid_m[N_CELL];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int xa, ya, xb, yb;
    int exp_wl;
    int exp_unpl;
    logic [2:0] exp_err;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  placement_checker #(.N(N), .N_NODE(N_NODE), .N_EDGE(N_EDGE)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .wirelength(wirelength), .occupied(occupied), .unplaced(unplaced), .err_flags(err_flags),
    .reEA(reEA), .addrEA(addrEA), .reEB(reEB), .addrEB(addrEB),
    .doutEA(doutEA), .doutEB(doutEB),
    .rePX(rePX), .addrPX(addrPX), .rePY(rePY), .addrPY(addrPY),
    .doutPX(doutPX), .doutPY(doutPY),
    .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
    .dbg_state(dbg_state)
  );

  // Synchronous-read memories: data appears the cycle after the strobe and is held.
  always @(posedge clk) begin
    if (reEA) doutEA <= (addrEA < N_EDGE) ? ea_m[addrEA[6:0]] : '0;
    if (reEB) doutEB <= (addrEB < N_EDGE) ? eb_m[addrEB[6:0]] : '0;
    if (rePX) doutPX <= (addrPX < 16) ? px_m[addrPX[3:0]] : '0;
    if (rePY) doutPY <= (addrPY < 16) ? py_m[addrPY[3:0]] : '0;
    if (reGrid) doutGrid <= (addrGrid < N_CELL) ? grid_m[addrGrid[3:0]] : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N_EDGE; i++) begin
      ea_m[i] = 0;
      eb_m[i] = 1;
    end
    for (int i = 0; i < 16; i++) begin
      px_m[i] = -1;
      py_m[i] = -1;
    end
    for (int i = 0; i < N_CELL; i++) grid_m[i] = -1;
  endtask

  function automatic int scan_cycles();
    int s = 0;
    if (!SCAN) return 0;
    for (int i = 0; i < N_CELL; i++)
      s += (grid_m[i] >= 0 && grid_m[i] < N_NODE) ? 6 : 3;
    return s;
  endfunction

  // One full run; lat counts cycles from the busy-rise cycle through the done cycle inclusive.
  task automatic run_once(output int lat, output int px_scan, output int grid_seen,
                          output bit busy_late, output bit tmo);
    int t_busy = -1;
    bit seen_ea = 1'b0;
    lat = -1; px_scan = 0; grid_seen = 0; tmo = 1'b1; busy_late = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (busy && t_busy < 0) t_busy = c;
      if (t_busy < 0 && c > 0) busy_late = 1'b1;
      if (reEA) seen_ea = 1'b1;
      if (rePX && !seen_ea) px_scan++;
      if (reGrid) grid_seen++;
      if (done) begin
        lat = c - t_busy + 1;
        tmo = 1'b0;
        break;
      end
      start = (c == 100);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, {27'd0, reEA, reEB, rePX, rePY, reGrid}, 32'd0);
    check({tag, "_addrs"}, addrEA | addrEB | addrPX | addrPY | addrGrid, 32'd0);
    check({tag, "_wl"}, wirelength, 32'd0);
    check({tag, "_counts"}, {occupied, unplaced}, 32'd0);
    check({tag, "_ctl"}, {27'd0, busy, done, err_flags}, 32'd0);
    check({tag, "_state"}, {27'd0, dbg_state}, 32'd0);
  endtask

  task automatic load_clean();
    clear_mem();
    px_m[0] = 0; py_m[0] = 0;
    px_m[1] = 2; py_m[1] = 3;
    grid_m[0]  = 0;
    grid_m[11] = 1;
  endtask

  int lat, px_scan, grid_seen;
  bit busy_late, tmo;
  int ea_cnt;
  bit hit;

  initial begin
    tbl[0] = '{0, 0, 2, 3, 316, 0, 3'b000};
    tbl[1] = '{1, 1, 1, 1, -79, 0, 3'b000};
    tbl[2] = '{3, 3, 0, 0, 395, 0, 3'b000};
    tbl[3] = '{1, 0, 0, 2, 158, 0, 3'b000};
    tbl[4] = '{2, 1, -1, 0, 0, 79, 3'b100};
    tbl[5] = '{4, 0, 0, 0, 0, 79, 3'b100};
    tbl[6] = '{0, 0, 0, -1, 0, 79, 3'b100};
    tbl[7] = '{3, 2, 2, 3, 79, 0, 3'b000};

    clear_mem();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Table: every edge joins node 0 and node 1 at the listed positions, grid empty.
    for (int i = 0; i < 8; i++) begin
      clear_mem();
      px_m[0] = tbl[i].xa; py_m[0] = tbl[i].ya;
      px_m[1] = tbl[i].xb; py_m[1] = tbl[i].yb;
      exp_q.push_back(tbl[i].exp_wl);
      run_once(lat, px_scan, grid_seen, busy_late, tmo);
      check($sformatf("vec%0d_timeout", i), {31'd0, tmo}, 32'd0);
      check($sformatf("vec%0d_wl", i), wirelength, exp_q.pop_front());
      check($sformatf("vec%0d_unplaced", i), {16'd0, unplaced}, tbl[i].exp_unpl);
      check($sformatf("vec%0d_err", i), {29'd0, err_flags}, {29'd0, tbl[i].exp_err});
      check($sformatf("vec%0d_occupied", i), {16'd0, occupied}, 32'd0);
      check($sformatf("vec%0d_latency", i), lat, scan_cycles() + 10 * N_EDGE + 1);
      check($sformatf("vec%0d_busy_rise", i), {31'd0, busy_late}, 32'd0);
    end

    // Consistent placement with two occupied cells.
    load_clean();
    run_once(lat, px_scan, grid_seen, busy_late, tmo);
    check("clean_timeout", {31'd0, tmo}, 32'd0);
    check("clean_wl", wirelength, 32'd316);
    check("clean_occupied", {16'd0, occupied}, SCAN ? 32'd2 : 32'd0);
    check("clean_err", {29'd0, err_flags}, 32'd0);
    check("clean_unplaced", {16'd0, unplaced}, 32'd0);
    check("clean_scan_pos_reads", px_scan, SCAN ? 32'd2 : 32'd0);
    check("clean_grid_reads", grid_seen, SCAN ? N_CELL : 0);
    check("clean_latency", lat, (SCAN ? 14 * 3 + 2 * 6 : 0) + 10 * N_EDGE + 1);
    @(negedge clk);
    check("clean_done_pulse", {30'd0, done, busy}, 32'd0);
    check("clean_wl_held", wirelength, 32'd316);

    // Cell 5 holds node 3 whose position maps to cell 14.
    load_clean();
    grid_m[0] = -1; grid_m[11] = -1;
    px_m[3] = 3; py_m[3] = 2;
    grid_m[5] = 3;
    run_once(lat, px_scan, grid_seen, busy_late, tmo);
    check("mism_err", {29'd0, err_flags}, SCAN ? 32'd2 : 32'd0);
    check("mism_occupied", {16'd0, occupied}, SCAN ? 32'd1 : 32'd0);
    check("mism_wl", wirelength, 32'd316);

    // Out-of-range ids in the grid: flagged, and no position read issued for them.
    load_clean();
    grid_m[0] = -1; grid_m[11] = -1;
    grid_m[7] = 20;
    grid_m[9] = -5;
    run_once(lat, px_scan, grid_seen, busy_late, tmo);
    check("badid_err", {29'd0, err_flags}, SCAN ? 32'd1 : 32'd0);
    check("badid_pos_reads", px_scan, 32'd0);
    check("badid_occupied", {16'd0, occupied}, 32'd0);
    check("badid_latency", lat, (SCAN ? N_CELL * 3 : 0) + 10 * N_EDGE + 1);

    // Reset during ACC of edge 40, then a fresh run must match the clean result.
    load_clean();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ea_cnt = 0;
    hit = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (reEA) begin
        ea_cnt++;
        if (ea_cnt == 41) begin
          repeat (9) @(negedge clk);
          hit = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    check("midreset_reached_acc", {31'd0, hit}, 32'd1);
    check("midreset_wl_before", wirelength, 32'd160);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("midreset");
    run_once(lat, px_scan, grid_seen, busy_late, tmo);
    check("rerun_timeout", {31'd0, tmo}, 32'd0);
    check("rerun_wl", wirelength, 32'd316);
    check("rerun_err", {29'd0, err_flags}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/placement_checker.md
# placement_checker

Post-placement verifier and cost reader for the placement flow. Once the placer has written the pos_X, pos_Y and grid memories, this block reads them back. Optionally, it scans every grid cell and checks that each occupied cell maps back to its node's recorded position. It then walks the edge list (ea/eb ROMs) and accumulates the Manhattan wirelength cost using the placer's rule: |dx| + |dy| − 1 per edge. It is the read-side counterpart of the placer and acts only as a master on the memories' read ports.

## Interface
Parameters:
- N, 9: grid side length; grid holds N*N cells, cell address = x*N + y.
- N_NODE, 11: number of node ids; valid ids are 0..N_NODE−1.
- N_EDGE, 79: number of edges in the ea/eb ROMs.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  begin a check run; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse in DONE.
- wirelength  out  32  signed accumulated cost; valid when done pulses, held until next start.
- occupied  out  16  count of non-empty grid cells.
- unplaced  out  16  count of edges skipped because an endpoint is off-grid.
- err_flags  out  3  [0] ERR_ID, [1] ERR_MISMATCH, [2] ERR_UNPLACED; sticky within a run.
- reEA/addrEA, reEB/addrEB  out  1/32  edge ROM reads.
- doutEA, doutEB  in  32  signed edge endpoint ids.
- rePX/addrPX, rePY/addrPY  out  1/32  position RAM reads; the write ports are never driven.
- doutPX, doutPY  in  32  signed coordinates; −1 means unplaced.
- reGrid/addrGrid  out  1/32  grid RAM read.
- doutGrid  in  32  signed node id; −1 means empty.

## Operation
- All outputs are registered. Reset value of every output is 0, including all re* strobes and addr* buses.
- Memory access: re*/addr* are asserted for exactly one cycle in an ISSUE state. They pass through a WAIT state. dout* is sampled in the following DATA state.
- States:
  - IDLE → (start) → GS_ISSUE, or EDGE_ISSUE if grid scan is compiled out.
  - Grid scan: GS_ISSUE → GS_WAIT → GS_DATA.
    - In GS_DATA, a value of −1 means empty: go to the next cell.
    - An id < 0 or ≥ N_NODE sets ERR_ID and goes to the next cell. No position read is issued.
    - Otherwise, increment occupied and go GP_ISSUE → GP_WAIT → GP_CMP.
    - In GP_CMP, if posX*N + posY ≠ cell, set ERR_MISMATCH.
    - After cell N*N−1, go to EDGE_ISSUE.
  - Wirelength pass, per edge e:
    - EDGE_ISSUE (addrEA = addrEB = e) → EDGE_WAIT → PA_ISSUE (addrPX/PY = ea) → PA_WAIT → PA_DATA → PB_ISSUE (= eb) → PB_WAIT → PB_DATA → ACC.
    - In ACC: if any of the four coordinates is outside [0, N−1], set ERR_UNPLACED, increment unplaced, and add nothing.
    - Otherwise add |xa−xb| + |ya−yb| − 1 to wirelength. Absolute values are taken on 32-bit signed differences.
    - After edge N_EDGE−1, go to DONE; otherwise go to EDGE_ISSUE.
  - DONE: done=1, busy=0 → IDLE.
- At start acceptance, wirelength, occupied, unplaced and err_flags are cleared.
- start while busy is ignored.
- N_EDGE = 0 goes directly to DONE after the grid scan, or immediately after IDLE if the scan is compiled out.
- The accumulator wraps modulo 2^32. Counters saturate at 16'hFFFF.
- Reset mid-run: at the next edge, the block returns to IDLE with all outputs at 0 and no strobe asserted.

## Timing
- start sampled high in IDLE → busy high on the next cycle.
- Grid scan cost per cell:
  - Empty or bad-id cell: 3 cycles.
  - Occupied cell: 6 cycles.
- Wirelength pass cost: 10 cycles per edge (EDGE 2, PA 3, PB 4, ACC 1; the PB_DATA→ACC boundary counts once).
- DONE: 1 cycle.
- Total with scan off: 10*N_EDGE + 1 cycles after busy rises.
- At most one outstanding read per memory. Strobes never overlap a WAIT state.

## Configuration
- CHECKER_GRID_SCAN_EN:
  - Defined: the grid-scan pass runs before the wirelength pass, and occupied, ERR_ID and ERR_MISMATCH are live.
  - Undefined: the GS/GP states are absent, reGrid is tied to 0, occupied is constant 0, and err_flags[1:0] is constant 0.

## Test plan
- N=4, N_EDGE=1. Node 0 at (0,0), node 1 at (2,3), grid consistent, scan on → wirelength=4, occupied=2, err_flags=0, unplaced=0.
- Edge whose endpoint b has posX=−1 → ERR_UNPLACED set, unplaced=1, wirelength unchanged by that edge.
- Grid cell 5 holds node 3 with pos (3,2) at N=4 (address 14) → err_flags[1]=1, occupied still counts the cell.
- Grid cell holds id 20 with N_NODE=11 → err_flags[0]=1, and rePX/rePY are not asserted for that cell.
- reset pulsed during ACC of edge 40 → next cycle all outputs are 0 and state is IDLE. A new start reproduces the clean-run wirelength exactly.
- Macro undefined, N_EDGE=79 → reGrid never high, done pulses exactly 791 cycles after busy rises.
